// File: rtl/rr_lock_pkg.sv
// Shared types and helpers for the round-robin lock arbiter.
//   state_t : arbiter FSM states (IDLE -> OWNED -> COOL -> IDLE)
//   MAX_N   : widest requester vector supported (16)
//   onehot  : index -> one-hot vector, masked to the first n bits
package rr_lock_pkg;

    localparam int MAX_N = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        COOL  = 2'd2
    } state_t;

    function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
        logic [MAX_N-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i == idx && i < n) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request bit at or after ptr,
// wrapping from N-1 back to 0.
// Ports:
//   req   in  N    request vector
//   ptr   in  IDW  search start index
//   valid out 1    at least one request present
//   idx   out IDW  chosen requester index (0 when !valid)
module rr_pick #(
    parameter int  N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           valid,
    output logic [IDW-1:0] idx
);

    logic [N-1:0]   rot;
    logic [IDW-1:0] off;
    logic [IDW-1:0] src;

    always_comb begin
        // NOTE: every variable driven here gets a default first so no path
        // leaves it unassigned -- that is what keeps a latch from being inferred.
        rot   = '0;
        off   = '0;
        src   = '0;
        valid = 1'b0;

        // Rotate so that bit 0 of rot is requester ptr.
        for (int i = 0; i < N; i++) begin
            src    = IDW'((int'(ptr) + i) % N);
            rot[i] = req[src];
        end

        // Lowest set bit of the rotated vector wins; scan high-to-low so the
        // last assignment is the lowest index.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                valid = 1'b1;
                off   = IDW'(i);
            end
        end
    end

    // Undo the rotation to get the absolute requester index.
    assign idx = valid ? IDW'((int'(ptr) + int'(off)) % N) : '0;

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter guarding one shared resource with a busy lock.
// A grant is held until the owner pulses rel, or until the hold counter
// reaches HOLD_MAX, which revokes the owner and flags timeout_err. Every
// exit from ownership passes through a single COOL cycle with no grant.
// Ports:
//   clk         in  1    rising-edge clock
//   rst         in  1    asynchronous active-high reset
//   req         in  N    level-sensitive requests
//   rel         in  N    release pulses
//   gnt         out N    one-hot registered grant
//   busy        out 1    resource owned (state == OWNED)
//   owner       out IDW  index of current owner, 0 when not busy
//   timeout_err out 1    one-cycle pulse when an owner is revoked
//   rel_err     out 1    one-cycle pulse on a rel bit from a non-owner
module rr_lock_arbiter
    import rr_lock_pkg::*;
#(
    parameter int  N        = 4,
    parameter int  HOLD_MAX = 15,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   rel,
    output logic [N-1:0]   gnt,
    output logic           busy,
    output logic [IDW-1:0] owner,
    output logic           timeout_err,
    output logic           rel_err
);

    localparam int             HCW       = $clog2(HOLD_MAX + 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_MAX);
    localparam logic [IDW-1:0] LAST_IDX  = IDW'(N - 1);

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_next;
    logic [HCW-1:0] hold_cnt;
    logic [HCW-1:0] hold_next;
    logic [N-1:0]   gnt_next;
    logic [IDW-1:0] owner_next;
    logic           timeout_next;
    logic           rel_err_next;

    logic           pick_valid;
    logic [IDW-1:0] pick_idx;
    logic           owner_rel;
    logic           hold_expired;
    logic           exit_owned;

    rr_pick #(.N(N)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign owner_rel    = (state == OWNED) && rel[owner];
    assign hold_expired = (state == OWNED) && (hold_cnt == HOLD_LAST);
    assign exit_owned   = owner_rel || hold_expired;
    assign busy         = (state == OWNED);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state elements use non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (pick_valid) state_next = OWNED;
            OWNED:   if (exit_owned) state_next = COOL;
            COOL:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer and hold counter.
    always_comb begin
        gnt_next     = gnt;
        owner_next   = owner;
        ptr_next     = ptr;
        hold_next    = hold_cnt;
        timeout_next = 1'b0;
        // gnt is zero outside OWNED, so in IDLE/COOL every rel bit is stray.
        rel_err_next = |(rel & ~gnt);

        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    gnt_next   = N'(onehot(int'(pick_idx), N));
                    owner_next = pick_idx;
                    hold_next  = '0;
                end
            end
            OWNED: begin
                if (exit_owned) begin
                    gnt_next     = '0;
                    owner_next   = '0;
                    hold_next    = '0;
                    ptr_next     = (owner == LAST_IDX) ? '0 : owner + IDW'(1);
                    // A release in the expiry cycle wins: no error.
                    timeout_next = !owner_rel;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_next = hold_cnt + HCW'(1);
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt         <= '0;
            owner       <= '0;
            ptr         <= '0;
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
            rel_err     <= 1'b0;
        end else begin
            gnt         <= gnt_next;
            owner       <= owner_next;
            ptr         <= ptr_next;
            hold_cnt    <= hold_next;
            timeout_err <= timeout_next;
            rel_err     <= rel_err_next;
        end
    end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter (N=4, HOLD_MAX=15).
module tb_rr_lock_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] owner;
    logic       timeout_err;
    logic       rel_err;

    int total = 0;
    int bad   = 0;

    rr_lock_arbiter #(.N(4), .HOLD_MAX(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .rel         (rel),
        .gnt         (gnt),
        .busy        (busy),
        .owner       (owner),
        .timeout_err (timeout_err),
        .rel_err     (rel_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Structural invariants sampled away from the active edge.
    always @(negedge clk) begin
        total++;
        if (!$onehot0(gnt) || (busy !== (gnt != 4'b0))) begin
            bad++;
            $display("FAIL invariant got gnt=%b busy=%b want onehot0 gnt and busy==(gnt!=0)", gnt, busy);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; rel = 4'b0000;
        tick(); tick();
        total++; if (gnt !== 4'b0000)   begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (owner !== 2'd0)    begin bad++; $display("FAIL reset_owner got=%0d want=0", owner); end
        total++; if (timeout_err !== 1'b0 || rel_err !== 1'b0)
            begin bad++; $display("FAIL reset_err got=%b%b want=00", timeout_err, rel_err); end
        rst = 1'b0;
        tick();
        total++; if (gnt !== 4'b0001)   begin bad++; $display("FAIL reset_first_gnt got=%b want=0001", gnt); end
        // Asynchronous assert mid-OWNED, between clock edges.
        #2 rst = 1'b1;
        #1;
        total++; if (gnt !== 4'b0000 || busy !== 1'b0)
            begin bad++; $display("FAIL reset_async got gnt=%b busy=%b want gnt=0000 busy=0", gnt, busy); end
        req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        req = 4'b0100;
        tick();
        total++; if (gnt !== 4'b0100)   begin bad++; $display("FAIL single_gnt got=%b want=0100", gnt); end
        total++; if (owner !== 2'd2)    begin bad++; $display("FAIL single_owner got=%0d want=2", owner); end
        req = 4'b0000;
        tick();
        total++; if (gnt !== 4'b0100)   begin bad++; $display("FAIL single_req_drop got=%b want=0100", gnt); end
        rel = 4'b0100;
        tick();
        rel = 4'b0000;
        total++; if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0)
            begin bad++; $display("FAIL single_release got gnt=%b busy=%b owner=%0d want 0000/0/0", gnt, busy, owner); end
        total++; if (rel_err !== 1'b0)  begin bad++; $display("FAIL single_rel_err got=%b want=0", rel_err); end
        req = 4'b0100;
        tick();
        total++; if (gnt !== 4'b0000)   begin bad++; $display("FAIL single_cool got=%b want=0000", gnt); end
        tick();
        total++; if (gnt !== 4'b0100)   begin bad++; $display("FAIL single_regrant got=%b want=0100", gnt); end
        rel = 4'b0100; req = 4'b0000;
        tick();
        rel = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        int         cyc;
        int         order [5] = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            want = 4'b0001 << order[k];
            cyc  = 0;
            do begin
                tick();
                cyc++;
            end while (gnt == 4'b0000 && cyc < 6);
            total++; if (gnt !== want)
                begin bad++; $display("FAIL rr_gnt[%0d] got=%b want=%b", k, gnt, want); end
            total++; if (owner !== 2'(order[k]))
                begin bad++; $display("FAIL rr_owner[%0d] got=%0d want=%0d", k, owner, order[k]); end
            total++; if (cyc !== ((k == 0) ? 1 : 2))
                begin bad++; $display("FAIL rr_latency[%0d] got=%0d want=%0d", k, cyc, (k == 0) ? 1 : 2); end
            rel = want;
            tick();
            rel = 4'b0000;
            total++; if (gnt !== 4'b0000)
                begin bad++; $display("FAIL rr_release[%0d] got=%b want=0000", k, gnt); end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_timeout();
        int held;
        int terr_seen;
        req = 4'b0010;
        tick();
        total++; if (gnt !== 4'b0010)   begin bad++; $display("FAIL to_gnt got=%b want=0010", gnt); end
        req = 4'b0111;
        held = 0; terr_seen = 0;
        while (gnt == 4'b0010 && held < 40) begin
            if (timeout_err) terr_seen++;
            held++;
            tick();
        end
        total++; if (held !== 16)       begin bad++; $display("FAIL to_hold_cycles got=%0d want=16", held); end
        total++; if (terr_seen !== 0)   begin bad++; $display("FAIL to_early_err got=%0d want=0", terr_seen); end
        total++; if (timeout_err !== 1'b1 || busy !== 1'b0)
            begin bad++; $display("FAIL to_revoke got terr=%b busy=%b want 1/0", timeout_err, busy); end
        tick();
        total++; if (timeout_err !== 1'b0 || gnt !== 4'b0000)
            begin bad++; $display("FAIL to_pulse got terr=%b gnt=%b want 0/0000", timeout_err, gnt); end
        tick();
        total++; if (gnt !== 4'b0100 || owner !== 2'd2)
            begin bad++; $display("FAIL to_next got gnt=%b owner=%0d want 0100/2", gnt, owner); end
        rel = 4'b0100; req = 4'b0000;
        tick();
        rel = 4'b0000;
        tick();
    endtask

    task automatic test_stray();
        req = 4'b0001;
        tick();
        total++; if (gnt !== 4'b0001)   begin bad++; $display("FAIL stray_gnt got=%b want=0001", gnt); end
        rel = 4'b1000;
        tick();
        rel = 4'b0000;
        total++; if (rel_err !== 1'b1)  begin bad++; $display("FAIL stray_err got=%b want=1", rel_err); end
        total++; if (busy !== 1'b1 || gnt !== 4'b0001)
            begin bad++; $display("FAIL stray_hold got busy=%b gnt=%b want 1/0001", busy, gnt); end
        tick();
        total++; if (rel_err !== 1'b0)  begin bad++; $display("FAIL stray_pulse got=%b want=0", rel_err); end
        rel = 4'b1001; req = 4'b0000;
        tick();
        rel = 4'b0000;
        total++; if (gnt !== 4'b0000 || busy !== 1'b0 || rel_err !== 1'b1 || timeout_err !== 1'b0)
            begin bad++; $display("FAIL stray_mixed got gnt=%b busy=%b rerr=%b terr=%b want 0000/0/1/0", gnt, busy, rel_err, timeout_err); end
        rel = 4'b0010;
        tick();
        rel = 4'b0000;
        total++; if (rel_err !== 1'b1)  begin bad++; $display("FAIL stray_idle got=%b want=1", rel_err); end
    endtask

    task automatic test_rel_at_timeout();
        req = 4'b0001;
        tick();
        total++; if (gnt !== 4'b0001)   begin bad++; $display("FAIL same_gnt got=%b want=0001", gnt); end
        repeat (15) tick();
        total++; if (gnt !== 4'b0001)   begin bad++; $display("FAIL same_still got=%b want=0001", gnt); end
        rel = 4'b0001; req = 4'b1111;
        tick();
        rel = 4'b0000;
        total++; if (gnt !== 4'b0000 || timeout_err !== 1'b0)
            begin bad++; $display("FAIL same_release got gnt=%b terr=%b want 0000/0", gnt, timeout_err); end
        tick();
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL same_no_err got=%b want=0", timeout_err); end
        tick();
        total++; if (gnt !== 4'b0010)   begin bad++; $display("FAIL same_next got=%b want=0010", gnt); end
        rel = 4'b0010; req = 4'b0000;
        tick();
        rel = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_stray();
        test_rel_at_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
